// File: rtl/riscv_pkg.sv
// Shared definitions for the memory port arbiter: default widths,
// starvation limit and the arbiter FSM state encoding.
package riscv_pkg;

   localparam int ADDR_W_DEF     = 32;
   localparam int DATA_W_DEF     = 32;
   localparam int STARVE_MAX_DEF = 4;

   typedef enum logic [1:0] {
      IDLE,
      GNT_I,
      GNT_D,
      RESP
   } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and shared memory port signals. The master
// modport is the arbiter's view; the slave modport is the view of the
// requesters and the memory that sit around it.
interface mem_port_arbiter_if
   import riscv_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);

   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              i_ack;
   logic [DATA_W-1:0] i_rdata;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_ack;
   logic [DATA_W-1:0] d_rdata;

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;

   logic              stall_if;
   logic              stall_mem;

   modport master (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
      output i_ack, i_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr,
             mem_wdata, stall_if, stall_mem
   );

   modport slave (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
      input  i_ack, i_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr,
             mem_wdata, stall_if, stall_mem
   );

endinterface

// File: rtl/starve_ctr.sv
// Saturating count of data grants issued while a fetch was waiting.
// at_max tells the arbiter that fetch must win the next contested grant.
module starve_ctr
   import riscv_pkg::*;
#(
   parameter int MAX = STARVE_MAX_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic inc,
   input  logic clr,
   output logic at_max
);

   localparam int W = $clog2(MAX + 1);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Clear wins over increment; increment stops once the limit is reached.
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc && !at_max) begin
         count_d = count_q + W'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign at_max = (count_q == W'(MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one shared memory port between an instruction fetch port and
// a data load/store port. Data normally wins a contested grant, but after
// STARVE_MAX consecutive data grants with fetch waiting, fetch goes first.
module mem_port_arbiter
   import riscv_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input logic              clk,
   input logic              reset,
   mem_port_arbiter_if.master bus
);

   arb_state_t        state_q, state_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              i_ack_q, i_ack_d;
   logic              d_ack_q, d_ack_d;
   logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

   logic grant_i;
   logic grant_d;
   logic starve_inc;
   logic starve_clr;
   logic starve_at_max;

   // Next-state and next-output logic; every output is registered so the
   // memory side sees a request and payload that stay put until mem_ack.
   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      i_ack_d     = 1'b0;
      d_ack_d     = 1'b0;
      i_rdata_d   = i_rdata_q;
      d_rdata_d   = d_rdata_q;
      grant_i     = 1'b0;
      grant_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.d_req && !(bus.i_req && starve_at_max)) begin
               grant_d     = 1'b1;
               state_d     = GNT_D;
               mem_req_d   = 1'b1;
               mem_we_d    = bus.d_we;
               mem_addr_d  = bus.d_addr;
               mem_wdata_d = bus.d_wdata;
            end else if (bus.i_req) begin
               grant_i     = 1'b1;
               state_d     = GNT_I;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b0;
               mem_addr_d  = bus.i_addr;
               mem_wdata_d = '0;
            end
         end
         GNT_I: begin
            if (bus.mem_ack) begin
               state_d   = RESP;
               mem_req_d = 1'b0;
               i_ack_d   = 1'b1;
               i_rdata_d = bus.mem_rdata;
            end
         end
         GNT_D: begin
            if (bus.mem_ack) begin
               state_d   = RESP;
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               d_ack_d   = 1'b1;
               if (!mem_we_q) begin
                  d_rdata_d = bus.mem_rdata;
               end
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      starve_inc = grant_d & bus.i_req;
      starve_clr = grant_i | (grant_d & ~bus.i_req);
   end

   // FSM and registered outputs; reset abandons any access in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         i_ack_q     <= 1'b0;
         d_ack_q     <= 1'b0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         i_ack_q     <= i_ack_d;
         d_ack_q     <= d_ack_d;
         i_rdata_q   <= i_rdata_d;
         d_rdata_q   <= d_rdata_d;
      end
   end

   starve_ctr #(
      .MAX(STARVE_MAX)
   ) u_starve_ctr (
      .clk   (clk),
      .reset (reset),
      .inc   (starve_inc),
      .clr   (starve_clr),
      .at_max(starve_at_max)
   );

   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.i_ack     = i_ack_q;
   assign bus.d_ack     = d_ack_q;
   assign bus.i_rdata   = i_rdata_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.stall_if  = bus.i_req & ~i_ack_q;
   assign bus.stall_mem = bus.d_req & ~d_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a table of per-cycle vectors for
// single fetch/store/load transactions, then hand-written sequences for
// contention, starvation, reset mid-access and spurious memory acks.
module tb_mem_port_arbiter;
   import riscv_pkg::*;

   logic clk = 1'b0;
   logic reset;

   int tests_run    = 0;
   int tests_failed = 0;

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   mem_port_arbiter_if bus ();

   mem_port_arbiter dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   typedef struct {
      logic        i_req;
      logic [31:0] i_addr;
      logic        d_req;
      logic        d_we;
      logic [31:0] d_addr;
      logic [31:0] d_wdata;
      logic        mem_ack;
      logic [31:0] mem_rdata;
      logic        e_mem_req;
      logic        e_mem_we;
      logic [31:0] e_mem_addr;
      logic [31:0] e_mem_wdata;
      logic        e_i_ack;
      logic        e_d_ack;
      logic        e_stall_if;
      logic        e_stall_mem;
      logic [31:0] e_i_rdata;
      logic [31:0] e_d_rdata;
   } vec_t;

   localparam int NVEC = 17;
   vec_t vecs [NVEC];

   // Moves from just after one falling edge to the next falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Compares one value and logs a failure line when it differs.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Single-bit wrapper around checkOutput.
   task automatic checkBit(input string name, input logic act, input logic exp);
      checkOutput(name, {31'b0, act}, {31'b0, exp});
   endtask

   // Drives the input half of a table vector onto the bus.
   task automatic applyStimulus(input vec_t v);
      bus.i_req     = v.i_req;
      bus.i_addr    = v.i_addr;
      bus.d_req     = v.d_req;
      bus.d_we      = v.d_we;
      bus.d_addr    = v.d_addr;
      bus.d_wdata   = v.d_wdata;
      bus.mem_ack   = v.mem_ack;
      bus.mem_rdata = v.mem_rdata;
   endtask

   // Compares every DUT output against the expected half of a vector.
   task automatic checkVector(input int k, input vec_t v);
      checkBit($sformatf("vec%0d.mem_req", k), bus.mem_req, v.e_mem_req);
      checkBit($sformatf("vec%0d.mem_we", k), bus.mem_we, v.e_mem_we);
      checkOutput($sformatf("vec%0d.mem_addr", k), bus.mem_addr, v.e_mem_addr);
      checkOutput($sformatf("vec%0d.mem_wdata", k), bus.mem_wdata, v.e_mem_wdata);
      checkBit($sformatf("vec%0d.i_ack", k), bus.i_ack, v.e_i_ack);
      checkBit($sformatf("vec%0d.d_ack", k), bus.d_ack, v.e_d_ack);
      checkBit($sformatf("vec%0d.stall_if", k), bus.stall_if, v.e_stall_if);
      checkBit($sformatf("vec%0d.stall_mem", k), bus.stall_mem, v.e_stall_mem);
      checkOutput($sformatf("vec%0d.i_rdata", k), bus.i_rdata, v.e_i_rdata);
      checkOutput($sformatf("vec%0d.d_rdata", k), bus.d_rdata, v.e_d_rdata);
   endtask

   // Main test sequence.
   initial begin
      int data_grants;
      logic fetch_seen;

      // One row per cycle, applied just after a falling edge.
      //            i_req i_addr  d_req d_we  d_addr  d_wdata mem_ack mem_rdata
      //            | mem_req mem_we mem_addr mem_wdata i_ack d_ack stall_if stall_mem i_rdata d_rdata
      // Fetch at 0x10, zero wait states.
      vecs[0]  = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
                   1'b0, 1'b0, 32'h0,  32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0};
      vecs[1]  = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h00A00093,
                   1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0};
      vecs[2]  = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
                   1'b0, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00A00093, 32'h0};
      // Spurious mem_ack in IDLE, then a quiet cycle.
      vecs[3]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hDEADBEEF,
                   1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00A00093, 32'h0};
      vecs[4]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
                   1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00A00093, 32'h0};
      // Store of 7 to 0x20 with three wait states.
      vecs[5]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h7, 1'b0, 32'h0,
                   1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00A00093, 32'h0};
      vecs[6]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h7, 1'b0, 32'h0,
                   1'b1, 1'b1, 32'h20, 32'h7, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00A00093, 32'h0};
      vecs[7]  = vecs[6];
      vecs[8]  = vecs[6];
      vecs[9]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h7, 1'b1, 32'h12345678,
                   1'b1, 1'b1, 32'h20, 32'h7, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00A00093, 32'h0};
      vecs[10] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h7, 1'b0, 32'h0,
                   1'b0, 1'b0, 32'h20, 32'h7, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00A00093, 32'h0};
      vecs[11] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
                   1'b0, 1'b0, 32'h20, 32'h7, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00A00093, 32'h0};
      // Load from 0x24 with one wait state.
      vecs[12] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h24, 32'h55, 1'b0, 32'h0,
                   1'b0, 1'b0, 32'h20, 32'h7, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00A00093, 32'h0};
      vecs[13] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h24, 32'h55, 1'b0, 32'h0,
                   1'b1, 1'b0, 32'h24, 32'h55, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00A00093, 32'h0};
      vecs[14] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h24, 32'h55, 1'b1, 32'hCAFEF00D,
                   1'b1, 1'b0, 32'h24, 32'h55, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00A00093, 32'h0};
      vecs[15] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h24, 32'h55, 1'b0, 32'h0,
                   1'b0, 1'b0, 32'h24, 32'h55, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00A00093, 32'hCAFEF00D};
      vecs[16] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
                   1'b0, 1'b0, 32'h24, 32'h55, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00A00093, 32'hCAFEF00D};

      // Reset state.
      reset         = 1'b1;
      bus.i_req     = 1'b0;
      bus.i_addr    = '0;
      bus.d_req     = 1'b0;
      bus.d_we      = 1'b0;
      bus.d_addr    = '0;
      bus.d_wdata   = '0;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      @(negedge clk);
      #1;
      checkBit("reset.mem_req", bus.mem_req, 1'b0);
      checkBit("reset.mem_we", bus.mem_we, 1'b0);
      checkOutput("reset.mem_addr", bus.mem_addr, 32'h0);
      checkOutput("reset.mem_wdata", bus.mem_wdata, 32'h0);
      checkBit("reset.i_ack", bus.i_ack, 1'b0);
      checkBit("reset.d_ack", bus.d_ack, 1'b0);
      checkOutput("reset.i_rdata", bus.i_rdata, 32'h0);
      checkOutput("reset.d_rdata", bus.d_rdata, 32'h0);
      reset = 1'b0;
      step();

      // Table-driven single transactions.
      for (int k = 0; k < NVEC; k++) begin
         applyStimulus(vecs[k]);
         #1;
         checkVector(k, vecs[k]);
         step();
      end

      // Simultaneous requests: data first, fetch in the following IDLE.
      bus.i_req  = 1'b1;
      bus.i_addr = 32'h40;
      bus.d_req  = 1'b1;
      bus.d_we   = 1'b0;
      bus.d_addr = 32'h80;
      bus.d_wdata = 32'h0;
      bus.mem_ack = 1'b0;
      #1;
      checkBit("both.c0.stall_if", bus.stall_if, 1'b1);
      checkBit("both.c0.mem_req", bus.mem_req, 1'b0);
      step();
      #1;
      checkBit("both.c1.mem_req", bus.mem_req, 1'b1);
      checkOutput("both.c1.mem_addr", bus.mem_addr, 32'h80);
      checkBit("both.c1.stall_if", bus.stall_if, 1'b1);
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'h11111111;
      step();
      bus.mem_ack = 1'b0;
      #1;
      checkBit("both.c2.d_ack", bus.d_ack, 1'b1);
      checkBit("both.c2.i_ack", bus.i_ack, 1'b0);
      checkOutput("both.c2.d_rdata", bus.d_rdata, 32'h11111111);
      checkBit("both.c2.stall_if", bus.stall_if, 1'b1);
      step();
      bus.d_req = 1'b0;
      #1;
      checkBit("both.c3.mem_req", bus.mem_req, 1'b0);
      checkBit("both.c3.d_ack", bus.d_ack, 1'b0);
      checkBit("both.c3.stall_if", bus.stall_if, 1'b1);
      step();
      #1;
      checkBit("both.c4.mem_req", bus.mem_req, 1'b1);
      checkOutput("both.c4.mem_addr", bus.mem_addr, 32'h40);
      checkBit("both.c4.mem_we", bus.mem_we, 1'b0);
      checkBit("both.c4.stall_if", bus.stall_if, 1'b1);
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'h22222222;
      step();
      bus.mem_ack = 1'b0;
      #1;
      checkBit("both.c5.i_ack", bus.i_ack, 1'b1);
      checkBit("both.c5.stall_if", bus.stall_if, 1'b0);
      checkOutput("both.c5.i_rdata", bus.i_rdata, 32'h22222222);
      step();
      bus.i_req = 1'b0;
      step();

      // Starvation: both held, zero-wait memory; expect 4 data grants, then fetch.
      bus.i_req   = 1'b1;
      bus.i_addr  = 32'h40;
      bus.d_req   = 1'b1;
      bus.d_we    = 1'b0;
      bus.d_addr  = 32'h80;
      bus.mem_ack = 1'b0;
      data_grants = 0;
      fetch_seen  = 1'b0;
      for (int c = 0; c < 60 && !fetch_seen; c++) begin
         #1;
         if (bus.mem_req) begin
            if (bus.mem_addr == 32'h40) begin
               fetch_seen = 1'b1;
            end else begin
               data_grants++;
            end
         end
         bus.mem_ack = bus.mem_req;
         if (!fetch_seen) begin
            step();
         end
      end
      checkBit("starve.fetch_granted", fetch_seen, 1'b1);
      checkOutput("starve.data_grants_before_fetch", 32'(data_grants), 32'd4);
      for (int c = 0; c < 10; c++) begin
         step();
         #1;
         if (bus.i_ack) bus.i_req = 1'b0;
         if (bus.d_ack) bus.d_req = 1'b0;
         bus.mem_ack = bus.mem_req;
      end
      checkBit("starve.drain.mem_req", bus.mem_req, 1'b0);
      checkBit("starve.drain.stall_if", bus.stall_if, 1'b0);
      checkBit("starve.drain.stall_mem", bus.stall_mem, 1'b0);
      bus.mem_ack = 1'b0;
      step();

      // Reset during GNT_D, then a late mem_ack must not produce d_ack.
      bus.d_req   = 1'b1;
      bus.d_we    = 1'b1;
      bus.d_addr  = 32'h30;
      bus.d_wdata = 32'h9;
      step();
      #1;
      checkBit("rst_mid.gnt.mem_req", bus.mem_req, 1'b1);
      checkOutput("rst_mid.gnt.mem_addr", bus.mem_addr, 32'h30);
      reset     = 1'b1;
      bus.d_req = 1'b0;
      #1;
      checkBit("rst_mid.mem_req", bus.mem_req, 1'b0);
      checkBit("rst_mid.mem_we", bus.mem_we, 1'b0);
      checkOutput("rst_mid.mem_addr", bus.mem_addr, 32'h0);
      checkOutput("rst_mid.mem_wdata", bus.mem_wdata, 32'h0);
      checkOutput("rst_mid.i_rdata", bus.i_rdata, 32'h0);
      checkOutput("rst_mid.d_rdata", bus.d_rdata, 32'h0);
      @(negedge clk);
      bus.mem_ack = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      step();
      bus.mem_ack = 1'b0;
      #1;
      checkBit("rst_mid.after1.d_ack", bus.d_ack, 1'b0);
      checkBit("rst_mid.after1.mem_req", bus.mem_req, 1'b0);
      step();
      #1;
      checkBit("rst_mid.after2.d_ack", bus.d_ack, 1'b0);
      checkBit("rst_mid.after2.i_ack", bus.i_ack, 1'b0);
      checkBit("rst_mid.after2.mem_req", bus.mem_req, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, address width.
REQ-002 Parameter: DATA_W, 32, data width.
REQ-003 Parameter: STARVE_MAX, 4, consecutive data grants allowed while fetch waits.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 i_req  in  1  fetch read request; held high until i_ack.
REQ-007 i_addr  in  ADDR_W  fetch address; stable while i_req high.
REQ-008 i_ack  out  1  one-cycle fetch completion pulse.
REQ-009 i_rdata  out  DATA_W  fetch read data; valid with i_ack, held afterwards.
REQ-010 d_req  in  1  data request; held high until d_ack.
REQ-011 d_we  in  1  data write enable (1 = store, 0 = load).
REQ-012 d_addr  in  ADDR_W  data address; stable while d_req high.
REQ-013 d_wdata  in  DATA_W  store data.
REQ-014 d_ack  out  1  one-cycle data completion pulse.
REQ-015 d_rdata  out  DATA_W  load data; valid with d_ack on loads.
REQ-016 mem_req  out  1  shared memory port request.
REQ-017 mem_we  out  1  shared port write enable.
REQ-018 mem_addr  out  ADDR_W  shared port address.
REQ-019 mem_wdata  out  DATA_W  shared port write data.
REQ-020 mem_ack  in  1  memory completion; any number of wait cycles >= 0.
REQ-021 mem_rdata  in  DATA_W  memory read data; valid with mem_ack.
REQ-022 stall_if  out  1  combinational: i_req & ~i_ack.
REQ-023 stall_mem  out  1  combinational: d_req & ~d_ack.

Function
REQ-024 FSM states SHALL be IDLE, GNT_I, GNT_D, RESP.
REQ-025 Requests SHALL be sampled only in IDLE; IDLE with no request stays IDLE.
REQ-026 IDLE, only i_req -> GNT_I; only d_req -> GNT_D; both -> GNT_D unless starve count == STARVE_MAX, then GNT_I.
REQ-027 In GNT_x, mem_req SHALL be 1 with owner's address/data registered at grant, held stable until mem_ack.
REQ-028 mem_we SHALL equal registered d_we in GNT_D and 0 in all other states.
REQ-029 GNT_x with mem_ack -> RESP; mem_ack outside GNT_I/GNT_D SHALL be ignored.
REQ-030 In RESP, exactly the owner's ack SHALL be 1 for one cycle, then -> IDLE unconditionally.
REQ-031 i_rdata SHALL load mem_rdata on the GNT_I->RESP edge; d_rdata SHALL load only on load completions; both otherwise hold.
REQ-032 Latency: request seen in IDLE at cycle N, mem_ack at N+1+W -> ack at N+2+W, IDLE at N+3+W.
REQ-033 Starve count SHALL increment (saturating at STARVE_MAX) on a GNT_D grant with i_req high, and clear on any GNT_I grant or a GNT_D grant with i_req low.
REQ-034 Requester deasserting req before ack is a protocol violation; the in-flight access SHALL still complete and ack.

Reset
REQ-035 reset SHALL immediately force IDLE, starve count 0, mem_req/mem_we/i_ack/d_ack 0, mem_addr/mem_wdata/i_rdata/d_rdata 0.
REQ-036 Reset mid-access SHALL abandon the access without an ack; a following mem_ack SHALL be ignored.

Structure
REQ-037 The FSM state enum and default parameter constants SHALL live in the shared package riscv_pkg.
REQ-038 The saturating starvation counter SHALL be a sub-module named starve_ctr.

Verification
REQ-039 i_req, i_addr=0x10, mem_ack 0 wait, mem_rdata=0x00A00093 -> i_ack 2 cycles after request sampled, i_rdata=0x00A00093.
REQ-040 d_req, d_we=1, d_addr=0x20, d_wdata=7, mem_ack after 3 waits -> mem_we=1, mem_addr=0x20, mem_wdata=7 for 4 cycles, d_ack, d_rdata unchanged.
REQ-041 i_req and d_req both high at once -> data granted first, fetch granted in the next IDLE, stall_if=1 throughout.
REQ-042 d_req held continuously and i_req held, STARVE_MAX=4 -> 4 data grants then 1 fetch grant.
REQ-043 reset pulsed during GNT_D with mem_ack arriving next cycle -> no d_ack, FSM IDLE, outputs 0.
REQ-044 Spurious mem_ack in IDLE -> no ack, no state change.
